// File: rtl/ifetch_queue.sv
// ---------------------------------------------------------------------------
// ifetch_queue -- instruction fetch front end feeding the decoder stage.
//
// Issues sequential word fetches to instruction memory, buffers the in-order
// responses in a DEPTH-entry FIFO and presents {instruction, PC} to decode.
// A redirect flushes the FIFO, restarts fetch at the target and marks every
// request still in flight as stale so its response is silently dropped.
//
// Build option:
//   IFQ_BYPASS_EN  when defined, a response arriving while the FIFO is empty
//                  (and nothing is being discarded or redirected) is shown to
//                  decode in the same cycle; it is pushed only if decode does
//                  not take it.
//
// Parameters:
//   DEPTH     FIFO entries and credit limit (power of two, >= 2)
//   RESET_PC  first fetch address after reset (word aligned)
//
// Ports:
//   i_clk, i_rst          clock (rising edge), asynchronous active-high reset
//   o_imem_req_valid      fetch request valid
//   i_imem_req_ready      memory accepts the request
//   o_imem_req_addr       fetch address (word aligned)
//   i_imem_rsp_valid      in-order response, never back-pressured
//   i_imem_rsp_data       fetched instruction word
//   o_inst_valid          instruction available to decode
//   i_inst_ready          decode consumes the instruction
//   o_inst, o_inst_pc     instruction word and its PC
//   i_redirect            branch/jump redirect pulse
//   i_redirect_pc         redirect target (bits [1:0] ignored)
//   o_outstanding         accepted requests not yet responded
// ---------------------------------------------------------------------------
module ifetch_queue #(
   parameter int unsigned DEPTH    = 4,
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic                         i_clk,
   input  logic                         i_rst,
   output logic                         o_imem_req_valid,
   input  logic                         i_imem_req_ready,
   output logic [31:0]                  o_imem_req_addr,
   input  logic                         i_imem_rsp_valid,
   input  logic [31:0]                  i_imem_rsp_data,
   output logic                         o_inst_valid,
   input  logic                         i_inst_ready,
   output logic [31:0]                  o_inst,
   output logic [31:0]                  o_inst_pc,
   input  logic                         i_redirect,
   input  logic [31:0]                  i_redirect_pc,
   output logic [$clog2(DEPTH+1)-1:0]   o_outstanding
);

   localparam int unsigned CW = $clog2(DEPTH + 1);  // counter width
   localparam int unsigned PW = $clog2(DEPTH);      // pointer width

   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
   localparam logic [CW+1:0] DEPTH_W = (CW + 2)'(DEPTH);

   typedef struct packed {
      logic [31:0] inst;
      logic [31:0] pc;
   } entry_t;

   entry_t          fifo_mem [DEPTH];
   entry_t          head;
   logic [PW-1:0]   rd_ptr;
   logic [PW-1:0]   wr_ptr;
   logic [CW-1:0]   fifo_count;
   logic [CW-1:0]   outstanding;
   logic [CW-1:0]   discard;
   logic [31:0]     fetch_pc;
   logic [31:0]     rsp_pc;

   logic            req_fire;
   logic            fifo_empty;
   logic            rsp_good;
   logic            bypass_hit;
   logic            push;
   logic            pop;
   logic [CW-1:0]   outstanding_nxt;
   logic [CW+1:0]   credit_used;
   logic [31:0]     redirect_pc_al;
   logic            unused_redirect_lsbs;

   assign redirect_pc_al       = {i_redirect_pc[31:2], 2'b00};
   assign unused_redirect_lsbs = ^i_redirect_pc[1:0];

   // Stale responses still occupy credit through both outstanding and
   // discard, so the sum is deliberately conservative after a redirect.
   assign credit_used = (CW + 2)'(fifo_count) + (CW + 2)'(outstanding)
                      + (CW + 2)'(discard);

   assign o_imem_req_valid = !i_rst && (credit_used < DEPTH_W);
   assign o_imem_req_addr  = fetch_pc;
   assign o_outstanding    = outstanding;

   assign req_fire   = o_imem_req_valid && i_imem_req_ready;
   assign fifo_empty = (fifo_count == '0);
   assign head       = fifo_mem[rd_ptr];

   // A response is kept only if it is not stale: nothing left to discard and
   // no redirect in the same cycle (which makes it stale as well).
   assign rsp_good = i_imem_rsp_valid && !i_redirect && (discard == '0);

`ifdef IFQ_BYPASS_EN
   assign bypass_hit = fifo_empty && rsp_good;
`else
   assign bypass_hit = 1'b0;
`endif

   assign push = rsp_good && !(bypass_hit && i_inst_ready);
   assign pop  = !fifo_empty && i_inst_ready;

   assign outstanding_nxt = outstanding + CW'(req_fire) - CW'(i_imem_rsp_valid);

   // NOTE: every output is given a default before the conditions so that no
   // path leaves a signal unassigned and no latch is inferred.
   always_comb begin
      o_inst_valid = 1'b0;
      o_inst       = '0;
      o_inst_pc    = '0;
      if (!fifo_empty) begin
         o_inst_valid = 1'b1;
         o_inst       = head.inst;
         o_inst_pc    = head.pc;
      end else if (bypass_hit) begin
         o_inst_valid = 1'b1;
         o_inst       = i_imem_rsp_data;
         o_inst_pc    = rsp_pc;
      end
   end

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge values regardless of statement or process order.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         fetch_pc    <= RESET_PC;
         rsp_pc      <= RESET_PC;
         rd_ptr      <= '0;
         wr_ptr      <= '0;
         fifo_count  <= '0;
         outstanding <= '0;
         discard     <= '0;
      end else begin
         outstanding <= outstanding_nxt;
         if (i_redirect) begin
            // Flush wins over any push/pop this cycle; everything in flight
            // after this cycle's handshakes becomes stale.
            fetch_pc   <= redirect_pc_al;
            rsp_pc     <= redirect_pc_al;
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            fifo_count <= '0;
            discard    <= outstanding_nxt;
         end else begin
            if (req_fire) begin
               fetch_pc <= fetch_pc + 32'd4;
            end
            if (rsp_good) begin
               rsp_pc <= rsp_pc + 32'd4;
            end
            if (i_imem_rsp_valid && (discard != '0)) begin
               discard <= discard - CW'(1);
            end
            if (push) begin
               wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
               rd_ptr <= rd_ptr + PW'(1);
            end
            fifo_count <= fifo_count + CW'(push) - CW'(pop);
         end
      end
   end

   // NOTE: the storage array has no reset; the pointers and count are reset,
   // and the outputs are gated by fifo_empty, so stale contents never leak.
   always_ff @(posedge i_clk) begin
      if (push) begin
         fifo_mem[wr_ptr] <= '{inst: i_imem_rsp_data, pc: rsp_pc};
      end
   end

   // Credit accounting invariants.
   a_no_overflow: assert property (@(posedge i_clk) disable iff (i_rst)
      push |-> (fifo_count < DEPTH_C));
   a_no_rsp_underflow: assert property (@(posedge i_clk) disable iff (i_rst)
      i_imem_rsp_valid |-> (outstanding != '0));
   a_outstanding_bound: assert property (@(posedge i_clk) disable iff (i_rst)
      outstanding <= DEPTH_C);
   a_discard_bound: assert property (@(posedge i_clk) disable iff (i_rst)
      discard <= outstanding);

endmodule
